// File: rtl/scalar_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scalar_writeback_arbiter_pkg
// Purpose : Shared types and constants for the scalar register file
//           writeback path (source encoding, default widths and depths,
//           destination one-hot helper).
// Ports   : none (package)
// Config  : default data width is 32; override via the DATA_WIDTH parameter.
// Revision: 1.0 - initial release
// ============================================================================
package scalar_writeback_arbiter_pkg;

    // Which producer owns the write port in the current cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_V2S  = 2'd2,
        WB_LSU  = 2'd3
    } wb_src_t;

    localparam int c_lsu_fifo_depth = 4;
    localparam int c_rd_width       = 5;
    localparam int c_num_regs       = 32;
    localparam int c_data_width     = 32;

    // One-hot of a destination register. Register 0 is the hardwired zero
    // register and never has a pending bit, so it maps to an empty mask.
    function automatic logic [c_num_regs-1:0] wb_rd_onehot(input logic [c_rd_width-1:0] rd);
        logic [c_num_regs-1:0] m;
        m = '0;
        if (rd != '0) begin
            m[rd] = 1'b1;
        end
        return m;
    endfunction

endpackage : scalar_writeback_arbiter_pkg
`default_nettype wire

// File: rtl/scalar_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : scalar_wb_fifo
// Purpose : Synchronous FIFO buffering load/store return packets {rd, data}
//           until they win the register file write port. The head entry is
//           presented combinationally so the arbiter can see it before pop.
// Ports   : clk, reset           - clock, synchronous active-high reset
//           push, push_data      - enqueue request / payload (ignored if full)
//           pop                  - dequeue head (ignored if empty)
//           head_data            - current head payload
//           full, empty          - occupancy flags
// Notes   : DEPTH must be a power of two and at least 2.
// Revision: 1.0 - initial release
// ============================================================================
module scalar_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  assign head_data = r_mem[r_rd_ptr];

  // A full FIFO refuses pushes even when the head is popping that cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule : scalar_wb_fifo
`default_nettype wire

// File: rtl/scalar_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : scalar_writeback_arbiter
// Purpose : Collects ALU, vector-to-scalar and load-return results, places
//           one per cycle on the scalar register file write port
//           (priority ALU > V2S > buffered LSU), and tracks per-register
//           pending writebacks so issue can stall on write-after-write.
// Ports   : clk, reset, enable          - clock, sync reset, warp enable
//           issue_valid/rd/ready        - issue-side scoreboard query
//           alu_valid/rd/data           - ALU result (never stalled)
//           v2s_valid/ready/rd/data     - vector-to-scalar handshake
//           lsu_valid/ready/rd/data     - load-return handshake (buffered)
//           wr_en/wr_rd/wr_data         - registered write port
//           pending_mask                - registered pending-destination bits
//           busy                        - pending work or buffered returns
//           bypass_valid/rd/data        - (optional) current winner forward
// Config  : SCALAR_WB_BYPASS_EN adds the combinational bypass outputs.
// Revision: 1.0 - initial release
// ============================================================================
module scalar_writeback_arbiter
  import scalar_writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = c_data_width,
  parameter int LSU_FIFO_DEPTH = c_lsu_fifo_depth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,

  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  issue_ready,

  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,

  input  logic                  v2s_valid,
  output logic                  v2s_ready,
  input  logic [4:0]            v2s_rd,
  input  logic [DATA_WIDTH-1:0] v2s_data,

  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,

  output logic                  wr_en,
  output logic [4:0]            wr_rd,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [31:0]           pending_mask,
  output logic                  busy
`ifdef SCALAR_WB_BYPASS_EN
  ,
  output logic                  bypass_valid,
  output logic [4:0]            bypass_rd,
  output logic [DATA_WIDTH-1:0] bypass_data
`endif
);

  localparam int c_entry_w = c_rd_width + DATA_WIDTH;

  // --------------------------------------------------------------------------
  // Load-return buffer
  // --------------------------------------------------------------------------
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [c_entry_w-1:0] w_fifo_head;
  logic                 w_lsu_push;
  logic                 w_fifo_pop;

  assign lsu_ready  = enable && !w_fifo_full;
  assign w_lsu_push = lsu_valid && lsu_ready;

  scalar_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH),
    .WIDTH (c_entry_w)
  ) u_lsu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_lsu_push),
    .push_data ({lsu_rd, lsu_data}),
    .pop       (w_fifo_pop),
    .head_data (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Write port arbitration
  // --------------------------------------------------------------------------
  // The ALU cannot be back-pressured, so V2S is refused in any cycle the
  // ALU presents a result rather than being buffered.
  assign v2s_ready = enable && !alu_valid;

  wb_src_t               w_src;
  logic [4:0]            w_win_rd;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_win_write;

  always_comb begin
    w_src      = WB_NONE;
    w_win_rd   = '0;
    w_win_data = '0;
    if (enable) begin
      if (alu_valid) begin
        w_src      = WB_ALU;
        w_win_rd   = alu_rd;
        w_win_data = alu_data;
      end else if (v2s_valid) begin
        w_src      = WB_V2S;
        w_win_rd   = v2s_rd;
        w_win_data = v2s_data;
      end else if (!w_fifo_empty) begin
        w_src      = WB_LSU;
        w_win_rd   = w_fifo_head[c_entry_w-1:DATA_WIDTH];
        w_win_data = w_fifo_head[DATA_WIDTH-1:0];
      end
    end
  end

  // A winner targeting register 0 is still consumed (and popped if it came
  // from the FIFO) but produces no register file write.
  assign w_fifo_pop  = (w_src == WB_LSU);
  assign w_win_write = (w_src != WB_NONE) && (w_win_rd != '0);

  logic                  r_wr_en;
  logic [4:0]            r_wr_rd;
  logic [DATA_WIDTH-1:0] r_wr_data;

  // Address and data hold their last value when nothing is written, so a
  // downstream observer never sees them toggle on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_win_write;
      if (w_win_write) begin
        r_wr_rd   <= w_win_rd;
        r_wr_data <= w_win_data;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_rd   = r_wr_rd;
  assign wr_data = r_wr_data;

  // --------------------------------------------------------------------------
  // Pending-destination scoreboard
  // --------------------------------------------------------------------------
  logic [31:0] r_pending;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic        w_issue_fire;

  assign issue_ready  = enable && ((issue_rd == '0) || !r_pending[issue_rd]);
  assign w_issue_fire = issue_valid && issue_ready;

  assign w_set_mask = w_issue_fire ? wb_rd_onehot(issue_rd) : '0;
  assign w_clr_mask = w_win_write  ? wb_rd_onehot(w_win_rd) : '0;

  // Set is applied after clear: a new issue to a register whose older
  // result is retiring this cycle must remain pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign pending_mask = r_pending;
  assign busy         = (r_pending != '0) || !w_fifo_empty;

  // --------------------------------------------------------------------------
  // Optional operand forwarding
  // --------------------------------------------------------------------------
`ifdef SCALAR_WB_BYPASS_EN
  assign bypass_valid = w_win_write;
  assign bypass_rd    = w_win_rd;
  assign bypass_data  = w_win_data;
`endif

  // --------------------------------------------------------------------------
  // Protocol check: the ALU must not produce results for a frozen warp,
  // since it has no way to hold them.
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_alu_requires_enable : assert property (
    @(posedge clk) disable iff (reset) (enable || !alu_valid)
  );
`endif

endmodule : scalar_writeback_arbiter
`default_nettype wire

// File: tb/tb_scalar_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_scalar_writeback_arbiter
// Purpose : Self-checking bench for scalar_writeback_arbiter. Expected
//           register file writes are queued as stimulus is applied and a
//           write-port monitor pops and compares them in order.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scalar_writeback_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          v2s_valid;
  logic          v2s_ready;
  logic [4:0]    v2s_rd;
  logic [DW-1:0] v2s_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          wr_en;
  logic [4:0]    wr_rd;
  logic [DW-1:0] wr_data;
  logic [31:0]   pending_mask;
  logic          busy;
`ifdef SCALAR_WB_BYPASS_EN
  logic          bypass_valid;
  logic [4:0]    bypass_rd;
  logic [DW-1:0] bypass_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW+4:0] exp_q[$];

  always #5 clk = ~clk;

  scalar_writeback_arbiter #(
    .DATA_WIDTH     (DW),
    .LSU_FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .v2s_valid    (v2s_valid),
    .v2s_ready    (v2s_ready),
    .v2s_rd       (v2s_rd),
    .v2s_data     (v2s_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .wr_en        (wr_en),
    .wr_rd        (wr_rd),
    .wr_data      (wr_data),
    .pending_mask (pending_mask),
    .busy         (busy)
`ifdef SCALAR_WB_BYPASS_EN
    ,
    .bypass_valid (bypass_valid),
    .bypass_rd    (bypass_rd),
    .bypass_data  (bypass_data)
`endif
  );

  // Write-port monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [DW+4:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", wr_rd, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_rd, wr_data} !== e)
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   wr_rd, wr_data, e[DW+4:DW], e[DW-1:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    v2s_valid = 1'b0; v2s_rd = '0; v2s_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b, required 0", wr_en); else n_pass++;
    n_checks++; if (wr_rd !== 5'd0) $display("FAIL reset_wr_rd: got %0d, required 0", wr_rd); else n_pass++;
    n_checks++; if (wr_data !== 32'd0) $display("FAIL reset_wr_data: got %h, required 0", wr_data); else n_pass++;
    n_checks++; if (pending_mask !== 32'd0) $display("FAIL reset_pending: got %h, required 0", pending_mask); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (lsu_ready !== 1'b1) $display("FAIL reset_lsu_ready: got %b, required 1", lsu_ready); else n_pass++;
  endtask

  task automatic test_alu_write();
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL alu_issue_ready: got %b, required 1", issue_ready); else n_pass++;
    tick();
    issue_valid = 1'b0;
    n_checks++; if (pending_mask[5] !== 1'b1) $display("FAIL alu_pending_set: got %b, required 1", pending_mask[5]); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL alu_busy: got %b, required 1", busy); else n_pass++;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    exp_q.push_back({5'd5, 32'h0000_1234});
`ifdef SCALAR_WB_BYPASS_EN
    #1;
    n_checks++;
    if ({bypass_valid, bypass_rd, bypass_data} !== {1'b1, 5'd5, 32'h0000_1234})
      $display("FAIL alu_bypass: got v=%b rd=%0d data=%h, required v=1 rd=5 data=00001234",
               bypass_valid, bypass_rd, bypass_data);
    else n_pass++;
`endif
    tick();
    alu_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd5) $display("FAIL alu_wr: got en=%b rd=%0d, required en=1 rd=5", wr_en, wr_rd); else n_pass++;
    n_checks++; if (pending_mask[5] !== 1'b0) $display("FAIL alu_pending_clr: got %b, required 0", pending_mask[5]); else n_pass++;
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL alu_drain: got %0d outstanding, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_priority();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5_0003;
    v2s_valid = 1'b1; v2s_rd = 5'd4; v2s_data = 32'h0BAD_0004;
    #1;
    n_checks++; if (v2s_ready !== 1'b0) $display("FAIL prio_v2s_blocked: got %b, required 0", v2s_ready); else n_pass++;
    exp_q.push_back({5'd3, 32'hA5A5_0003});
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++; if (v2s_ready !== 1'b1) $display("FAIL prio_v2s_ready: got %b, required 1", v2s_ready); else n_pass++;
    n_checks++; if (wr_rd !== 5'd3) $display("FAIL prio_alu_first: got rd=%0d, required 3", wr_rd); else n_pass++;
    exp_q.push_back({5'd4, 32'h0BAD_0004});
    tick();
    v2s_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd4) $display("FAIL prio_v2s_second: got en=%b rd=%0d, required en=1 rd=4", wr_en, wr_rd); else n_pass++;
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL prio_drain: got %0d outstanding, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_lsu_backpressure();
    int cnt = 0;
    int pushed = 0;
    logic [DW+4:0] hold_q[$];
    for (int cyc = 0; cyc < 30 && pushed < 5; cyc++) begin
      logic alu_on;
      logic exp_ready;
      logic do_pop;
      alu_on = (cyc < 6);
      // LSU results may only be written once the ALU stream has ended.
      if (!alu_on) while (hold_q.size() != 0) exp_q.push_back(hold_q.pop_front());
      alu_valid = alu_on; alu_rd = 5'(10 + cyc); alu_data = 32'hA000 + 32'(cyc);
      lsu_valid = 1'b1;   lsu_rd = 5'(16 + pushed); lsu_data = 32'hC000 + 32'(pushed);
      #1;
      exp_ready = (cnt < 4);
      n_checks++;
      if (lsu_ready !== exp_ready)
        $display("FAIL lsu_ready_cyc%0d: got %b, required %b", cyc, lsu_ready, exp_ready);
      else n_pass++;
      if (alu_on) exp_q.push_back({alu_rd, alu_data});
      do_pop = !alu_on && (cnt > 0);
      if (exp_ready) begin
        if (alu_on) hold_q.push_back({lsu_rd, lsu_data});
        else        exp_q.push_back({lsu_rd, lsu_data});
        pushed++;
      end
      cnt = cnt + (exp_ready ? 1 : 0) - (do_pop ? 1 : 0);
      tick();
    end
    idle_inputs();
    n_checks++; if (pushed != 5) $display("FAIL lsu_all_accepted: got %0d, required 5", pushed); else n_pass++;
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL lsu_drain: got %0d outstanding, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL lsu_idle_busy: got %b, required 0", busy); else n_pass++;
  endtask

  task automatic test_hazard();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL waw_first_issue: got %b, required 1", issue_ready); else n_pass++;
    tick();
    n_checks++; if (issue_ready !== 1'b0) $display("FAIL waw_stall: got %b, required 0", issue_ready); else n_pass++;
    tick();
    n_checks++; if (pending_mask[7] !== 1'b1) $display("FAIL waw_pending7: got %b, required 1", pending_mask[7]); else n_pass++;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_7777;
    exp_q.push_back({5'd7, 32'h0000_7777});
    #1;
    n_checks++; if (issue_ready !== 1'b0) $display("FAIL waw_stall_during_wb: got %b, required 0", issue_ready); else n_pass++;
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL waw_release: got %b, required 1", issue_ready); else n_pass++;
    issue_valid = 1'b0;
    // Issue and writeback of the same register in one cycle: issue must win.
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_8888;
    issue_valid = 1'b1; issue_rd = 5'd8;
    exp_q.push_back({5'd8, 32'h0000_8888});
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL setclr_issue_ready: got %b, required 1", issue_ready); else n_pass++;
    tick();
    idle_inputs();
    n_checks++; if (pending_mask[8] !== 1'b1) $display("FAIL setclr_set_wins: got %b, required 1", pending_mask[8]); else n_pass++;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_8889;
    exp_q.push_back({5'd8, 32'h0000_8889});
    tick();
    alu_valid = 1'b0;
    n_checks++; if (pending_mask !== 32'd0) $display("FAIL setclr_cleared: got %h, required 0", pending_mask); else n_pass++;
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL waw_drain: got %0d outstanding, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL rd0_issue_ready: got %b, required 1", issue_ready); else n_pass++;
    tick();
    idle_inputs();
    n_checks++; if (wr_en !== 1'b0) $display("FAIL rd0_no_write: got %b, required 0", wr_en); else n_pass++;
    n_checks++;
    if (wr_rd !== 5'd8 || wr_data !== 32'h0000_8889)
      $display("FAIL rd0_hold: got rd=%0d data=%h, required rd=8 data=00008889", wr_rd, wr_data);
    else n_pass++;
    n_checks++; if (pending_mask !== 32'd0) $display("FAIL rd0_pending: got %h, required 0", pending_mask); else n_pass++;
  endtask

  task automatic test_enable_low();
    enable = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'hDEAD_0001;
    v2s_valid = 1'b1; v2s_rd = 5'd2; v2s_data = 32'hDEAD_0002;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    n_checks++;
    if ({lsu_ready, v2s_ready, issue_ready} !== 3'b000)
      $display("FAIL en_low_ready: got lsu=%b v2s=%b issue=%b, required all 0", lsu_ready, v2s_ready, issue_ready);
    else n_pass++;
    tick();
    n_checks++; if (wr_en !== 1'b0) $display("FAIL en_low_wr_en: got %b, required 0", wr_en); else n_pass++;
    n_checks++;
    if (pending_mask !== 32'd0 || busy !== 1'b0)
      $display("FAIL en_low_state: got pend=%h busy=%b, required 0/0", pending_mask, busy);
    else n_pass++;
    idle_inputs();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1;   alu_rd = 5'(24 + k); alu_data = 32'hB000 + 32'(k);
      lsu_valid = 1'b1;   lsu_rd = 5'(1 + k);  lsu_data = 32'hE000 + 32'(k);
      issue_valid = 1'b1; issue_rd = 5'(20 + k);
      exp_q.push_back({alu_rd, alu_data});
      tick();
    end
    idle_inputs();
    n_checks++; if (pending_mask !== 32'h0070_0000) $display("FAIL rstmid_pending: got %h, required 00700000", pending_mask); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b, required 1", busy); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL rstmid_wr_en: got %b, required 0", wr_en); else n_pass++;
    n_checks++; if (pending_mask !== 32'd0) $display("FAIL rstmid_pending_clr: got %h, required 0", pending_mask); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", busy); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if (wr_en !== 1'b0) $display("FAIL rstmid_quiet_%0d: got %b, required 0", c, wr_en); else n_pass++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rstmid_drain: got %0d outstanding, required 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_priority();
    test_lsu_backpressure();
    test_hazard();
    test_rd_zero();
    test_enable_low();
    test_reset_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_scalar_writeback_arbiter
`default_nettype wire

// File: doc/scalar_writeback_arbiter.md
# scalar_writeback_arbiter

Write-side producer for the per-warp scalar register file. Collects results from the ALU, the load/store unit and the vector-to-scalar path, arbitrates them onto the register file's single write port, and keeps a pending-destination scoreboard so issue can stall on write-after-write hazards. Sits between the execute units and the scalar register file inside each warp slice.

## Interface
- DATA_WIDTH, `DATA_WIDTH (32), width of data words
- LSU_FIFO_DEPTH, 4, LSU return buffer entries (power of two, ≥2)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  warp enable; low freezes the block
- issue_valid  in  1  instruction with scalar destination is issuing
- issue_rd  in  5  its destination register
- issue_ready  out  1  issue may proceed (combinational)
- alu_valid  in  1  ALU result present (cannot be stalled)
- alu_rd / alu_data  in  5 / DATA_WIDTH  ALU destination / value
- v2s_valid, v2s_ready  in/out  1  vector-to-scalar handshake
- v2s_rd / v2s_data  in  5 / DATA_WIDTH
- lsu_valid, lsu_ready  in/out  1  load-return handshake
- lsu_rd / lsu_data  in  5 / DATA_WIDTH
- wr_en  out  1  register file write strobe (registered)
- wr_rd / wr_data  out  5 / DATA_WIDTH  write address / value (registered)
- pending_mask  out  32  bit r set while register r awaits writeback (registered)
- busy  out  1  any pending bit set or FIFO non-empty

## Operation
- Transfer on valid && ready; lsu_ready = enable && !fifo_full; v2s_ready = enable && !alu_valid.
- LSU transfers enqueue into the FIFO; ALU and V2S are never buffered.
- Per-cycle winner priority: ALU > V2S > FIFO head. FIFO head pops only when it wins.
- Winner with rd ≠ 0: next edge wr_en=1, wr_rd/wr_data = winner; pending bit rd cleared. Winner with rd = 0: consumed, wr_en stays 0.
- No winner: wr_en=0; wr_rd/wr_data hold.
- Scoreboard: issue_ready = enable && (issue_rd == 0 || !pending_mask[issue_rd]). Accepted issue with rd ≠ 0 sets its bit next edge.
- Same cycle set and clear of one bit: set wins.
- enable low: no pops, no issues, wr_en=0, state held; alu_valid high while enable low is a protocol error (assertion).

## Timing
- Reset values: wr_en 0, wr_rd 0, wr_data 0, pending_mask 0, busy 0, FIFO empty.
- ALU/V2S accepted cycle N -> wr_en in cycle N+1.
- LSU accepted cycle N -> earliest pop N+1 -> wr_en N+2; each cycle of ALU/V2S traffic adds one cycle.
- FIFO full: lsu_ready low; no push in a full cycle, even if popping.
- Pointers wrap modulo LSU_FIFO_DEPTH; count width $clog2(depth)+1.
- Reset mid-operation: FIFO contents and pending bits discarded; wr_en low in the cycle after reset.

## Configuration
- SCALAR_WB_BYPASS_EN defined: extra outputs bypass_valid (1), bypass_rd (5), bypass_data (DATA_WIDTH), driven combinationally with the current winner (valid only for rd ≠ 0), so operand read can forward one cycle before wr_en.
- Undefined: bypass ports and logic absent; behaviour otherwise identical.

## Structure
- Shared package: wb_src_t enum {WB_NONE, WB_ALU, WB_V2S, WB_LSU}; default LSU_FIFO_DEPTH constant.
- One sub-module: scalar_wb_fifo (synchronous FIFO with push/pop/full/empty, data = {rd, data}).

## Test plan
- Issue rd=5, then ALU rd=5 data 0x1234 -> wr_en next cycle with wr_rd=5, wr_data=0x1234; pending_mask[5] 1 -> 0 on that same edge.
- ALU rd=3 and V2S rd=4 in the same cycle -> v2s_ready=0; ALU written first, V2S written one cycle later.
- Five back-to-back LSU returns with ALU busy each cycle -> lsu_ready drops after 4; all 5 later written in arrival order.
- Issue rd=7 while pending[7]=1 -> issue_ready=0; after writeback of 7, issue_ready=1.
- ALU rd=0 data 0xFFFF -> wr_en stays 0; issue rd=0 always ready, pending_mask unchanged.
- Reset asserted with 3 FIFO entries and pending bits set -> pending_mask 0, busy 0, no wr_en afterward.
